// File: rtl/dac_frame_sequencer.sv
// Frame sequencer feeding a 4-channel SPI DAC driver.
// Channel codes collect in shadow registers and are committed atomically as one 32-bit frame.
// Each commit issues a start pulse, then the frame is held for the whole serial transfer.
// One commit can queue behind a busy transfer.
// An optional timer re-sends the last committed frame while the block is idle.
module dac_frame_sequencer #(
    parameter int unsigned START_CYCLES   = 64,   // o_start_n low time; >= 33 for the driver's sampler
    parameter int unsigned HOLD_CYCLES    = 4096, // frame freeze after the start pulse
    parameter int unsigned REFRESH_CYCLES = 0     // idle cycles before auto-reissue; 0 disables
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_en,
    input  logic [1:0]  i_wr_ch,
    input  logic [7:0]  i_wr_data,
    input  logic        i_load,
    output logic [31:0] o_dac_data,
    output logic        o_start_n,
    output logic        o_busy,
    output logic        o_pending
);

    // One counter is shared by START, HOLD and the idle refresh timer.
    // It is sized so that none of the three ever wraps.
    localparam int unsigned MaxSh     = (START_CYCLES > HOLD_CYCLES) ? START_CYCLES : HOLD_CYCLES;
    localparam int unsigned MaxCycles = (MaxSh > REFRESH_CYCLES) ? MaxSh : REFRESH_CYCLES;
    localparam int unsigned CntW      = (MaxCycles < 2) ? 1 : $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] StartLast   = CntW'(START_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast    = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] RefreshLast = CntW'(REFRESH_CYCLES);
    localparam bit              RefreshEn   = (REFRESH_CYCLES != 0);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StHold
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            req_q;
    logic            committed_q;
    logic [7:0]      shadow_q [4];
    logic [7:0]      shadow_d [4];
    logic [31:0]     frame_next;
    logic            issue_req;
    logic            issue_refresh;

    // Shadow next-state includes this cycle's write, so a write and a load in the same cycle
    // commit the written value.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (i_wr_en) begin
            shadow_d[i_wr_ch] = i_wr_data;
        end
        frame_next = {shadow_d[3], shadow_d[2], shadow_d[1], shadow_d[0]};
    end

    // Issue conditions evaluated in IDLE; a pending or fresh commit outranks the refresh timer.
    always_comb begin
        issue_req     = req_q | i_load;
        issue_refresh = RefreshEn && committed_q && (cnt_q == RefreshLast);
    end

    // Shadow register file, writable in every state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // Transfer sequencer with registered outputs.
    // The frame only changes on the START-entry edge or on reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            committed_q <= 1'b0;
            o_dac_data  <= 32'h0;
            o_start_n   <= 1'b1;
            o_busy      <= 1'b0;
            o_pending   <= 1'b0;
        end else begin
            if (i_load) begin
                committed_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (issue_req) begin
                        o_dac_data <= frame_next;
                        o_start_n  <= 1'b0;
                        o_busy     <= 1'b1;
                        o_pending  <= 1'b0;
                        req_q      <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= StStart;
                    end else if (issue_refresh) begin
                        // Refresh re-sends the committed frame; uncommitted shadow writes stay out.
                        o_start_n <= 1'b0;
                        o_busy    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StStart;
                    end else if (RefreshEn && committed_q) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStart: begin
                    if (i_load) begin
                        req_q     <= 1'b1;
                        o_pending <= 1'b1;
                    end
                    if (cnt_q == StartLast) begin
                        o_start_n <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StHold;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHold: begin
                    if (i_load) begin
                        req_q     <= 1'b1;
                        o_pending <= 1'b1;
                    end
                    if (cnt_q == HoldLast) begin
                        // IDLE entry restarts the refresh timer from zero.
                        o_busy  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Scoreboard bench for dac_frame_sequencer.
// The model predicts each cycle's outputs from transfer start times and counts of elapsed cycles.
module tb_dac_frame_sequencer;

    localparam int S = 64;
    localparam int H = 4096;
    localparam int R = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = 2'd0;
    logic [7:0]  wr_data = 8'h00;
    logic        load = 1'b0;
    logic [31:0] dac_data;
    logic        start_n;
    logic        busy;
    logic        pending;

    always #5 clk = ~clk;

    dac_frame_sequencer #(
        .START_CYCLES   (S),
        .HOLD_CYCLES    (H),
        .REFRESH_CYCLES (R)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (wr_en),
        .i_wr_ch    (wr_ch),
        .i_wr_data  (wr_data),
        .i_load     (load),
        .o_dac_data (dac_data),
        .o_start_n  (start_n),
        .o_busy     (busy),
        .o_pending  (pending)
    );

    typedef struct packed {
        logic        start_n;
        logic        busy;
        logic        pending;
        logic [31:0] data;
    } obs_t;

    obs_t        exp_q [$];
    logic [31:0] ev_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          armed = 1'b0;
    logic        prev_sn = 1'b1;

    // Reference model state: start cycle of the latest transfer and the first idle cycle after it.
    int          m_s = -1;
    int          m_idle = 0;
    logic [7:0]  m_sh [4];
    logic [31:0] m_frame = 32'h0;
    bit          m_commit = 1'b0;
    bit          m_req = 1'b0;
    bit          m_pend = 1'b0;

    task automatic model_step(input bit r, input bit we, input logic [1:0] ch,
                              input logic [7:0] d, input bit ld, output obs_t e);
        int t;
        bit idle_now;
        t = cyc + 1;
        if (r) begin
            for (int i = 0; i < 4; i++) m_sh[i] = 8'h00;
            m_frame  = 32'h0;
            m_commit = 1'b0;
            m_req    = 1'b0;
            m_pend   = 1'b0;
            m_s      = -1;
            m_idle   = t;
        end else begin
            if (we) m_sh[ch] = d;
            if (ld) begin
                m_req    = 1'b1;
                m_commit = 1'b1;
            end
            idle_now = (m_s < 0) || (cyc >= m_s + S + H);
            if (idle_now) begin
                if (m_s >= 0) m_idle = m_s + S + H;
                if (m_req) begin
                    m_s     = t;
                    m_frame = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
                    m_req   = 1'b0;
                    m_pend  = 1'b0;
                    ev_q.push_back(m_frame);
                end else if (m_commit && (cyc - m_idle == R)) begin
                    m_s = t;
                    ev_q.push_back(m_frame);
                end
            end else if (ld) begin
                m_pend = 1'b1;
            end
        end
        e.busy    = (m_s >= 0) && (t < m_s + S + H);
        e.start_n = !((m_s >= 0) && (t < m_s + S));
        e.pending = m_pend;
        e.data    = m_frame;
    endtask

    task automatic drive(input bit r, input bit we, input logic [1:0] ch,
                         input logic [7:0] d, input bit ld);
        obs_t e;
        @(posedge clk);
        #1;
        rst     = r;
        wr_en   = we;
        wr_ch   = ch;
        wr_data = d;
        load    = ld;
        model_step(r, we, ch, d, ld, e);
        exp_q.push_back(e);
        cyc++;
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] d, input bit ld);
        drive(1'b0, 1'b1, ch, d, ld);
    endtask

    // Monitor: one comparison of all outputs per cycle, plus the issued frame at each start.
    always @(negedge clk) begin
        obs_t e;
        obs_t got;
        logic [31:0] f;
        if (armed) begin
            got = {start_n, busy, pending, dac_data};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL queue_empty cycle=%0d got %h required an expected entry", cyc, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL cycle_outputs t=%0d got sn=%b busy=%b pend=%b data=%h required sn=%b busy=%b pend=%b data=%h",
                             cyc, got.start_n, got.busy, got.pending, got.data,
                             e.start_n, e.busy, e.pending, e.data);
                end
            end
            if (prev_sn === 1'b1 && start_n === 1'b0) begin
                n_cmp++;
                if (ev_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_start t=%0d got data=%h required no start", cyc, dac_data);
                end else begin
                    f = ev_q.pop_front();
                    if (dac_data !== f) begin
                        n_bad++;
                        $display("FAIL issued_frame t=%0d got %h required %h", cyc, dac_data, f);
                    end
                end
            end
            prev_sn = start_n;
        end
        if (mon_en) armed = 1'b1;
    end

    initial begin
        bit r;
        bit we;
        bit ld;
        for (int i = 0; i < 4; i++) m_sh[i] = 8'h00;

        // Reset, then a full transfer of 0x78563412.
        drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        wr(2'd0, 8'h12, 1'b0);
        wr(2'd1, 8'h34, 1'b0);
        wr(2'd2, 8'h56, 1'b0);
        wr(2'd3, 8'h78, 1'b1);
        idle(4200);

        // Write and commit in the same cycle; then two coalesced commits during HOLD.
        wr(2'd2, 8'hAA, 1'b1);
        idle(200);
        wr(2'd1, 8'h01, 1'b1);
        idle(5);
        wr(2'd1, 8'h02, 1'b1);
        idle(4400);

        // Shadow writes without commit never reach the outputs; no refresh without a commit.
        drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            if (i % 10 == 0) wr(2'(i / 10), 8'hFF, 1'b0);
            else idle(1);
        end

        // Periodic refresh of 0x11223344; the later uncommitted 0xFF must stay out.
        drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        wr(2'd0, 8'h44, 1'b0);
        wr(2'd1, 8'h33, 1'b0);
        wr(2'd2, 8'h22, 1'b0);
        wr(2'd3, 8'h11, 1'b1);
        idle(50);
        wr(2'd0, 8'hFF, 1'b0);
        idle(13000);

        // Reset during cycle 30 of START aborts; nothing resumes afterwards.
        drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        idle(29);
        drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        idle(300);

        // Random traffic.
        for (int i = 0; i < 25000; i++) begin
            r  = ($urandom_range(0, 7999) == 0);
            we = ($urandom_range(0, 3) == 0);
            ld = ($urandom_range(0, 299) == 0);
            drive(r, we, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), ld);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (ev_q.size() != 0) begin
            n_bad++;
            $display("FAIL events_outstanding got %0d unissued required 0", ev_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
